// File: rtl/elevator_call_scheduler_if.sv
// elevator_call_scheduler_if: call buttons and car status of the elevator call scheduler.
// Under DOOR_HOLD_EN it also carries door_hold_btn.
interface elevator_call_scheduler_if;
  logic [1:0] hall_up_btn;
  logic [1:0] hall_dwn_btn;
  logic [2:0] car_btn;
  logic [1:0] current_flr;
  logic is_moving;
  logic is_moving_up;
  logic is_moving_dwn;
  logic is_door_close;
  logic [6:0] pending_calls;
`ifdef DOOR_HOLD_EN
  logic door_hold_btn;
  modport master(output hall_up_btn, hall_dwn_btn, car_btn, door_hold_btn,
                 input current_flr, is_moving, is_moving_up, is_moving_dwn, is_door_close, pending_calls);
  modport slave(input hall_up_btn, hall_dwn_btn, car_btn, door_hold_btn,
                output current_flr, is_moving, is_moving_up, is_moving_dwn, is_door_close, pending_calls);
`else
  modport master(output hall_up_btn, hall_dwn_btn, car_btn,
                 input current_flr, is_moving, is_moving_up, is_moving_dwn, is_door_close, pending_calls);
  modport slave(input hall_up_btn, hall_dwn_btn, car_btn,
                output current_flr, is_moving, is_moving_up, is_moving_dwn, is_door_close, pending_calls);
`endif
endinterface

// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: SCAN-style collective call scheduler for a 3-floor car.
// Defining DOOR_HOLD_EN adds door_hold_btn, which holds the door open while high.
module elevator_call_scheduler #(
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES = 6,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  elevator_call_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MOVING, DOOR_OPEN} state_t;
  typedef enum logic [1:0] {NONE, UP, DN} dir_t;
  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LD = CNT_W'(DOOR_CYCLES - 1);
  state_t state;
  dir_t dir;
  logic [CNT_W-1:0] cnt;
  logic [6:0] pend, served, btn, car_m, hu_m, hd_m, stop_m, clr;
  logic [3:0] call_at;
  logic [1:0] flr;
  logic chk, mv, mv_up, mv_dn, door_close;
  logic here, above, below, ahead, stop, go_up, hold, restart;
`ifdef DOOR_HOLD_EN
  assign hold = bus.door_hold_btn;
`else
  assign hold = 1'b0;
`endif
  assign bus.current_flr = flr;
  assign bus.is_moving = mv;
  assign bus.is_moving_up = mv_up;
  assign bus.is_moving_dwn = mv_dn;
  assign bus.is_door_close = door_close;
  assign bus.pending_calls = pend;
  always_comb begin
    btn = {bus.car_btn, bus.hall_dwn_btn, bus.hall_up_btn};
    call_at = {1'b0, pend[6] | pend[3], pend[5] | pend[2] | pend[1], pend[4] | pend[0]};
    here = call_at[flr];
    above = flr == 2'd0 ? |call_at[2:1] : flr == 2'd1 ? call_at[2] : 1'b0;
    below = flr == 2'd2 ? |call_at[1:0] : flr == 2'd1 ? call_at[0] : 1'b0;
    go_up = above && (dir != DN || !below);
    car_m = 7'b0010000 << flr;
    hu_m = flr == 2'd0 ? 7'b0000001 : flr == 2'd1 ? 7'b0000010 : 7'b0;
    hd_m = flr == 2'd1 ? 7'b0000100 : flr == 2'd2 ? 7'b0001000 : 7'b0;
    ahead = dir == UP ? above : below;
    // with nothing further ahead the car reverses here, so every hall call at this floor is served
    stop_m = car_m | (dir == UP ? hu_m : hd_m) | (ahead ? 7'b0 : hu_m | hd_m);
    stop = |(pend & stop_m) || (dir == UP && flr == 2'd2) || (dir == DN && flr == 2'd0);
    clr = state == IDLE && here ? car_m | hu_m | hd_m : state == MOVING && chk && stop ? stop_m : 7'b0;
    restart = state == DOOR_OPEN && (|(btn & served) || hold);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dir <= NONE;
      cnt <= '0;
      chk <= 1'b0;
      pend <= '0;
      served <= '0;
      flr <= '0;
      mv <= 1'b0;
      mv_up <= 1'b0;
      mv_dn <= 1'b0;
      door_close <= 1'b1;
    end else begin
      pend <= state == DOOR_OPEN ? (pend | btn) & ~served : (pend & ~clr) | btn;
      case (state)
        IDLE:
          if (here) begin
            state <= DOOR_OPEN;
            cnt <= DOOR_LD;
            served <= clr;
            door_close <= 1'b0;
          end else if (above || below) begin
            state <= MOVING;
            dir <= go_up ? UP : DN;
            cnt <= TRAVEL_LD;
            chk <= 1'b0;
            mv <= 1'b1;
            mv_up <= go_up;
            mv_dn <= !go_up;
          end else dir <= NONE;
        MOVING:
          if (chk && stop) begin
            state <= DOOR_OPEN;
            cnt <= DOOR_LD;
            served <= clr;
            chk <= 1'b0;
            mv <= 1'b0;
            mv_up <= 1'b0;
            mv_dn <= 1'b0;
            door_close <= 1'b0;
          end else if (!chk && cnt == '0) begin
            flr <= dir == UP ? flr + 2'd1 : flr - 2'd1;
            cnt <= TRAVEL_LD;
            chk <= 1'b1;
          end else begin
            // the stop-check cycle doubles as the first travel cycle of the next floor
            cnt <= cnt - 1'b1;
            chk <= 1'b0;
          end
        DOOR_OPEN:
          if (restart) cnt <= DOOR_LD;
          else if (cnt == '0) begin
            state <= IDLE;
            door_close <= 1'b1;
          end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
endmodule
